// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM controller: FSM states, address field
// positions within the 25-bit byte address, and default timing values.
package sdram_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, PRE, ACT, RD_LO, RD_HI, RD_END, WR_LO, WR_HI, WR_END, PRE_ALL, REF
    } state_t;

    localparam int ADDR_W    = 25;
    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;
    localparam int ROW_W     = 13;
    localparam int COL_W     = 9;
    localparam int COLW_W    = 8;
    localparam int BANK_LSB  = 23;
    localparam int ROW_LSB   = 10;
    localparam int COLW_LSB  = 2;

    localparam int DLY_W     = 8;

    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_RFC        = 7;
    localparam int DEF_REF_INTERVAL = 780;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pending on expiry and holds it
// until the controller reports the refresh finished. Repeat expiries merge into one.
module sdram_refresh_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_done,
    output logic ref_pending
);

    localparam int CNT_W = $clog2(REF_INTERVAL);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;

    // A fresh expiry wins over a same-cycle ref_done so no interval is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= CNT_W'(REF_INTERVAL - 1);
            r_pending <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt     <= CNT_W'(REF_INTERVAL - 1);
            r_pending <= 1'b1;
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (ref_done) r_pending <= 1'b0;
        end
    end

    assign ref_pending = r_pending;

endmodule

// File: rtl/sdram_ctrl.sv
// Single-requester SDRAM sequencer: one 32-bit request becomes two 16-bit beats, with
// per-bank open-row tracking and periodic refresh. Response at T+3 (+T_RCD, +T_RP).
module sdram_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [BANK_W-1:0] mem_bank,
    output logic [ROW_W-1:0]  mem_row,
    output logic [COL_W-1:0]  mem_col,
    output logic              mem_wen,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    output logic              mem_ren,
    input  logic [15:0]       mem_rdata,
    output logic              busy
);

    state_t                           r_state, w_state_nxt;
    logic [DLY_W-1:0]                 r_dly, w_dly_load;
    logic                             r_wen;
    logic [BANK_W-1:0]                r_bank;
    logic [ROW_W-1:0]                 r_row;
    logic [COLW_W-1:0]                r_colw;
    logic [31:0]                      r_wdata;
    logic [3:0]                       r_wstrb;
    logic [15:0]                      r_rd_lo;
    logic [NUM_BANKS-1:0]             r_open;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  r_open_row;

    logic              w_ref_pending, w_ref_done, w_accept, w_dly_zero;
    logic              w_set_open, w_clr_open, w_beat_hi;
    logic [BANK_W-1:0] w_req_bank;
    logic [ROW_W-1:0]  w_req_row;
    logic              w_unused_addr_lsb;

    assign w_req_bank        = req_addr[BANK_LSB +: BANK_W];
    assign w_req_row         = req_addr[ROW_LSB +: ROW_W];
    assign w_unused_addr_lsb = ^req_addr[COLW_LSB-1:0];
    assign w_dly_zero        = (r_dly == '0);
    assign w_accept          = req_valid && req_ready;

    sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .ref_done    (w_ref_done),
        .ref_pending (w_ref_pending)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ref_done  = 1'b0;
        w_set_open  = 1'b0;
        w_clr_open  = 1'b0;
        case (r_state)
            IDLE: begin
                // Pending refresh outranks a same-cycle request.
                if (w_ref_pending)                             w_state_nxt = (|r_open) ? PRE_ALL : REF;
                else if (req_valid && !r_open[w_req_bank])     w_state_nxt = ACT;
                else if (req_valid && (r_open_row[w_req_bank] != w_req_row)) w_state_nxt = PRE;
                else if (req_valid)                            w_state_nxt = req_wen ? WR_LO : RD_LO;
            end
            PRE: if (w_dly_zero) begin
                w_state_nxt = ACT;
                w_clr_open  = 1'b1;
            end
            ACT: if (w_dly_zero) begin
                w_state_nxt = r_wen ? WR_LO : RD_LO;
                w_set_open  = 1'b1;
            end
            RD_LO:   w_state_nxt = RD_HI;
            RD_HI:   w_state_nxt = RD_END;
            RD_END:  w_state_nxt = IDLE;
            WR_LO:   w_state_nxt = WR_HI;
            WR_HI:   w_state_nxt = WR_END;
            WR_END:  w_state_nxt = IDLE;
            PRE_ALL: if (w_dly_zero) w_state_nxt = REF;
            REF: if (w_dly_zero) begin
                w_state_nxt = IDLE;
                w_ref_done  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (w_state_nxt)
            PRE, PRE_ALL: w_dly_load = DLY_W'(T_RP - 1);
            ACT:          w_dly_load = DLY_W'(T_RCD - 1);
            REF:          w_dly_load = DLY_W'(T_RFC - 1);
            default:      w_dly_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_dly   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_dly <= w_dly_load;
            else if (!w_dly_zero)       r_dly <= r_dly - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen      <= 1'b0;
            r_bank     <= '0;
            r_row      <= '0;
            r_colw     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rd_lo    <= '0;
            r_open     <= '0;
            r_open_row <= '0;
        end else begin
            if (w_accept) begin
                r_wen   <= req_wen;
                r_bank  <= w_req_bank;
                r_row   <= w_req_row;
                r_colw  <= req_addr[COLW_LSB +: COLW_W];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            if (r_state == RD_HI) r_rd_lo <= mem_rdata;
            if (w_ref_done) begin
                r_open <= '0;
            end else if (w_clr_open) begin
                r_open[r_bank] <= 1'b0;
            end else if (w_set_open) begin
                r_open[r_bank]     <= 1'b1;
                r_open_row[r_bank] <= r_row;
            end
        end
    end

    assign w_beat_hi  = (r_state == RD_HI) || (r_state == WR_HI);
    assign req_ready  = (r_state == IDLE) && !w_ref_pending;
    assign busy       = (r_state != IDLE);
    assign mem_bank   = r_bank;
    assign mem_row    = r_row;
    assign mem_col    = {r_colw, w_beat_hi};
    assign mem_ren    = (r_state == RD_LO) || (r_state == RD_HI);
    assign mem_wen    = (r_state == WR_LO) || (r_state == WR_HI);
    assign mem_wdata  = (r_state == WR_LO) ? r_wdata[15:0] :
                        (r_state == WR_HI) ? r_wdata[31:16] : 16'h0;
    assign mem_wmask  = (r_state == WR_LO) ? r_wstrb[1:0] :
                        (r_state == WR_HI) ? r_wstrb[3:2] : 2'b00;
    assign resp_valid = (r_state == RD_END) || (r_state == WR_END);
    assign resp_rdata = (r_state == RD_END) ? {mem_rdata, r_rd_lo} : 32'h0;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl with a behavioural 16-bit storage model, a beat
// scoreboard and a response scoreboard holding expected data and arrival cycle.
module tb_sdram_ctrl;

    localparam int T_RP = 2, T_RCD = 2, T_RFC = 7, REF_IV = 40;

    typedef struct packed {
        logic        wen;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [8:0]  col;
        logic [15:0] wdata;
        logic [1:0]  wmask;
    } beat_t;

    logic        clk, rst, req_valid, req_ready, req_wen;
    logic [24:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  mem_bank;
    logic [12:0] mem_row;
    logic [8:0]  mem_col;
    logic        mem_wen, mem_ren, busy;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_rdata = 16'h0;

    int n_chk = 0, n_fail = 0, cyc = 0, r_rel = 0;
    logic [3:0]  m_open;
    int          m_row [4];
    beat_t       exp_beat [$];
    logic [31:0] exp_rdata [$];
    int          exp_cyc [$];
    logic [15:0] store [int];

    sdram_ctrl #(.T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC), .REF_INTERVAL(REF_IV)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_bank(mem_bank),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int key(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
        return int'({b, r, c});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Storage model: byte mask bit set means that byte is written; read data lags one cycle.
    always @(posedge clk) begin : storage
        int k;
        logic [15:0] old;
        k = key(mem_bank, mem_row, mem_col);
        old = store.exists(k) ? store[k] : 16'h0;
        if (mem_ren) mem_rdata <= old;
        if (mem_wen) store[k] = {mem_wmask[1] ? mem_wdata[15:8] : old[15:8],
                                 mem_wmask[0] ? mem_wdata[7:0]  : old[7:0]};
    end

    always @(negedge clk) begin : monitor
        beat_t e_b, o_b;
        logic [31:0] e_rd;
        int e_cy;
        check("excl", {mem_ren & mem_wen, (mem_wen ? 18'h0 : {mem_wdata, mem_wmask})}, 64'h0);
        if (mem_ren || mem_wen) begin
            if (exp_beat.size() == 0) check("beat_unexp", {mem_ren, mem_wen}, 64'h0);
            else begin
                e_b = exp_beat.pop_front();
                o_b = {mem_wen, mem_bank, mem_row, mem_col, mem_wdata, mem_wmask};
                check("beat", o_b, e_b);
            end
        end
        if (resp_valid) begin
            if (exp_cyc.size() == 0) check("resp_unexp", resp_valid, 64'h0);
            else begin
                e_rd = exp_rdata.pop_front();
                e_cy = exp_cyc.pop_front();
                check("resp_data", resp_rdata, e_rd);
                check("resp_cycle", cyc, e_cy);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_resp"}, {resp_valid, resp_rdata, busy}, 64'h0);
        check({tag, "_mem"}, {mem_bank, mem_row, mem_col, mem_wen, mem_wdata, mem_wmask, mem_ren}, 64'h0);
        check({tag, "_ready"}, req_ready, 64'h1);
    endtask

    task automatic issue(input logic wen, input logic [24:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rd,
                         output int t_acc, output int t_resp);
        int n, lat;
        logic [1:0]  b;
        logic [12:0] r;
        b = addr[24:23];
        r = addr[22:10];
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 60) begin @(negedge clk); n++; end
        if (!req_ready) check("ready_timeout", req_ready, 64'h1);
        t_acc = cyc;
        if (m_open[b] && m_row[b] == int'(r)) lat = 3;
        else if (m_open[b])                  lat = 3 + T_RP + T_RCD;
        else                                 lat = 3 + T_RCD;
        m_open[b] = 1'b1;
        m_row[b]  = int'(r);
        exp_beat.push_back(beat_t'({wen, b, r, addr[9:2], 1'b0,
                                    wen ? wdata[15:0] : 16'h0, wen ? wstrb[1:0] : 2'b00}));
        exp_beat.push_back(beat_t'({wen, b, r, addr[9:2], 1'b1,
                                    wen ? wdata[31:16] : 16'h0, wen ? wstrb[3:2] : 2'b00}));
        exp_rdata.push_back(exp_rd);
        exp_cyc.push_back(t_acc + lat);
        t_resp = t_acc + lat;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        int ta, tr, n, last_resp, exp_gap, post;
        logic refreshed;
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        m_open = '0;
        store[key(2'd0, 13'd5, 9'd2)] = 16'hBEEF;
        store[key(2'd0, 13'd5, 9'd3)] = 16'hDEAD;
        store[key(2'd0, 13'd6, 9'd2)] = 16'hCAFE;
        store[key(2'd0, 13'd6, 9'd3)] = 16'h0123;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        r_rel = cyc;

        // Closed bank, row hit, masked write, read-back, then row miss to row 6.
        issue(1'b0, 25'h0001404, 32'h0, 4'h0, 32'hDEADBEEF, ta, tr);
        issue(1'b0, 25'h0001404, 32'h0, 4'h0, 32'hDEADBEEF, ta, tr);
        issue(1'b1, 25'h0001404, 32'h12345678, 4'b0110, 32'h0, ta, tr);
        issue(1'b0, 25'h0001404, 32'h0, 4'h0, 32'hDE3456EF, ta, tr);
        issue(1'b0, 25'h0001804, 32'h0, 4'h0, 32'h0123CAFE, ta, tr);

        // Row 6 must now be open: RD_HI two cycles after accept; reset lands there.
        issue(1'b0, 25'h0001804, 32'h0, 4'h0, 32'h0123CAFE, ta, tr);
        @(negedge clk);
        n = 0;
        while (!(mem_ren && mem_col[0]) && n < 10) begin @(negedge clk); n++; end
        check("rdhi_cycle", cyc, ta + 2);
        rst = 1'b1;
        void'(exp_rdata.pop_back());
        void'(exp_cyc.pop_back());
        m_open = '0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        r_rel = cyc;

        // Back-to-back reads until one refresh has been absorbed between requests.
        refreshed = 1'b0;
        post = 0;
        last_resp = 0;
        for (int k = 0; k < 20; k++) begin
            exp_gap = 1;
            if (k > 0 && !refreshed && last_resp + 1 >= r_rel + REF_IV) begin
                exp_gap = (|m_open) ? (1 + T_RP + T_RFC + 1) : (1 + T_RFC + 1);
                m_open = '0;
                refreshed = 1'b1;
            end
            issue(1'b0, 25'h0001804, 32'h0, 4'h0, 32'h0123CAFE, ta, tr);
            if (k > 0) check("accept_gap", ta - last_resp, exp_gap);
            last_resp = tr;
            if (refreshed) post++;
            if (post >= 3) break;
        end

        n = 0;
        while (exp_cyc.size() != 0 && n < 40) begin @(negedge clk); n++; end
        check("resp_drain", exp_cyc.size(), 64'h0);
        check("beat_drain", exp_beat.size(), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_ctrl.md
Name: sdram_ctrl

Overview:
- Single-requester controller that sequences the 16-bit banked SDRAM storage model (2-bit bank, 13-bit row, 9-bit column, 16-bit data, 2-bit byte mask, read data registered one cycle after the read enable).
- Converts 32-bit word requests from the SoC bus side into two 16-bit beats.
- Tracks open rows per bank and enforces precharge/activate delays.
- Inserts periodic refresh.
- Sits between the AXI/APB bridge and the storage model.

Parameters:
- T_RP, 2, precharge delay cycles (>=1)
- T_RCD, 2, activate-to-access delay cycles (>=1)
- T_RFC, 7, refresh busy cycles (>=1)
- REF_INTERVAL, 780, cycles between refresh requests (>= T_RP+T_RFC+8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_wen  in  1  1=write, 0=read
- req_addr  in  25  byte address; [24:23] bank, [22:10] row, [9:2] word column, [1:0] ignored
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  32  read data, valid with resp_valid on reads, 0 on writes
- mem_bank  out  2  storage bank
- mem_row  out  13  storage row
- mem_col  out  9  storage column
- mem_wen  out  1  storage write enable
- mem_wdata  out  16  storage write data
- mem_wmask  out  2  storage write mask
- mem_ren  out  1  storage read enable
- mem_rdata  in  16  storage read data, valid the cycle after mem_ren
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - all outputs 0, state IDLE
  - all bank open flags cleared, open-row registers 0
  - refresh counter loaded with REF_INTERVAL-1, ref_pending 0
- Reset mid-operation drops the in-flight request; no resp_valid is produced for it.
- req_ready = (state==IDLE) && !ref_pending.
- On handshake: latch wen, bank, row, word column, wdata and wstrb. Beat columns are {colw,0} and {colw,1}; no wrap is possible.
- Next state after accept:
  - bank open, same row: access state
  - bank open, different row: PRE
  - bank closed: ACT
- PRE: T_RP cycles, then clear that bank's open flag and go to ACT.
- ACT: T_RCD cycles, then set the open flag and open row; go to access state.
- Read access sequence:
  - RD_LO: mem_ren=1, col even.
  - RD_HI: mem_ren=1, col odd; latch mem_rdata as the low half.
  - RD_END: resp_valid=1, resp_rdata={mem_rdata, low half}; then IDLE.
- Write access sequence:
  - WR_LO: mem_wen=1, wdata[15:0], wmask=wstrb[1:0].
  - WR_HI: mem_wen=1, wdata[31:16], wmask=wstrb[3:2].
  - WR_END: resp_valid=1; then IDLE.
  - wstrb==0 still issues both beats with mask 0.
- Latency from accept cycle T: resp_valid at T+3 on a row hit, T+3+T_RCD if the bank is closed, T+3+T_RP+T_RCD on a row miss.
- mem_bank/row/col hold the latched request outside access beats. mem_wdata and mem_wmask are 0 when mem_wen=0.
- Refresh:
  - Counter decrements every cycle in all states. At 0 it sets ref_pending and reloads.
  - Expiry while ref_pending is already set is absorbed (one refresh serves).
  - In IDLE, ref_pending has priority over req_valid in the same cycle.
  - Sequence: PRE_ALL (T_RP cycles, only if any bank is open) → REF (T_RFC cycles) → clear all open flags and ref_pending → IDLE.
- An in-progress request always completes before refresh starts.
- mem_ren and mem_wen are never both 1.

Decomposition:
- Package sdram_ctrl_pkg:
  - state enum {IDLE, PRE, ACT, RD_LO, RD_HI, RD_END, WR_LO, WR_HI, WR_END, PRE_ALL, REF}
  - address field widths and bit positions
  - default timing constants
- Sub-module sdram_refresh_timer: counter plus ref_pending flag, with inputs ref_done.

Test Plan:
- Read to closed bank 0, row 5, addr 0x0001404, with storage preloaded 0xBEEF at col 2 and 0xDEAD at col 3 → ACT for 2 cycles, resp_rdata=0xDEADBEEF at T+5.
- Second read to the same row → no PRE/ACT, resp_valid at T+3.
- Write 0x12345678 with wstrb=4'b0110 to the open row → beats (0x5678, mask 2'b10) then (0x1234, mask 2'b01); read-back shows only bytes 1..2 changed.
- Access to bank 0 row 6 while row 5 is open → PRE 2 cycles + ACT 2 cycles, resp_valid at T+7; open row becomes 6.
- REF_INTERVAL=40 with back-to-back requests → at expiry, req_ready drops after the current request; PRE_ALL 2 cycles then REF 7 cycles; the next read to row 6 requires ACT.
- Assert rst during RD_HI → next cycle all outputs 0, no resp_valid, busy=0; a subsequent request issues ACT (open flags cleared).
